// File: rtl/pgr_apb_cmd_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : pgr_apb_cmd_arb_if
// Brief    : Bundles both requester command ports and the shared APB master
//            bus of the two-requester APB command arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface pgr_apb_cmd_arb_if #(
  parameter int AW = 16,
  parameter int DW = 32,
  parameter int SW = 4
);
  // requester 0 (UART command bridge)
  logic          req0_en;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic [SW-1:0] req0_strb;
  logic          req0_we;
  logic          req0_done;
  logic [DW-1:0] req0_rdata;
  logic          req0_err;
  // requester 1 (debug/config agent)
  logic          req1_en;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic [SW-1:0] req1_strb;
  logic          req1_we;
  logic          req1_done;
  logic [DW-1:0] req1_rdata;
  logic          req1_err;
  // APB master side
  logic          p_sel;
  logic          p_ce;
  logic          p_we;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata;
  logic [SW-1:0] p_strb;
  logic          p_rdy;
  logic [DW-1:0] p_rdata;
  logic          gnt_id;

  // arbiter view: consumes commands, drives the APB bus
  modport master (
    input  req0_en, req0_addr, req0_wdata, req0_strb, req0_we,
    output req0_done, req0_rdata, req0_err,
    input  req1_en, req1_addr, req1_wdata, req1_strb, req1_we,
    output req1_done, req1_rdata, req1_err,
    output p_sel, p_ce, p_we, p_addr, p_wdata, p_strb, gnt_id,
    input  p_rdy, p_rdata
  );

  // environment view: requesters plus APB slave
  modport slave (
    output req0_en, req0_addr, req0_wdata, req0_strb, req0_we,
    input  req0_done, req0_rdata, req0_err,
    output req1_en, req1_addr, req1_wdata, req1_strb, req1_we,
    input  req1_done, req1_rdata, req1_err,
    input  p_sel, p_ce, p_we, p_addr, p_wdata, p_strb, gnt_id,
    output p_rdy, p_rdata
  );
endinterface
`default_nettype wire

// File: rtl/pgr_apb_cmd_arb.sv
`default_nettype none
// ============================================================================
// Module   : pgr_apb_cmd_arb
// Brief    : Round-robin arbiter between two held-command requesters and a
//            single APB transfer sequencer with an ACCESS-phase watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module pgr_apb_cmd_arb #(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int SW      = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  pgr_apb_cmd_arb_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  // last ACCESS cycle index before the watchdog fires
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t        state;
  state_t        state_nxt;
  logic          last_gnt;
  logic          gnt_r;
  logic [15:0]   timer;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r;
  logic [SW-1:0] strb_r;
  logic          we_r;
  logic [DW-1:0] rdata_r;
  logic          err_r;
  logic          req_any;
  logic          winner;
  logic          rdy_hit;
  logic          tmo_hit;
  logic          done0;
  logic          done1;

  // Grant selection, completion conditions and next-state decode
  always_comb begin
    state_nxt = state;
    req_any   = bus.req0_en | bus.req1_en;
    // contention goes to the requester not served last; otherwise the one asking
    winner    = (bus.req0_en && bus.req1_en) ? ~last_gnt : bus.req1_en;
    rdy_hit   = (state == ACCESS) && bus.p_rdy;
    // ready in the final cycle takes priority over the watchdog
    tmo_hit   = (state == ACCESS) && !bus.p_rdy && (timer == TMO_LAST);
    case (state)
      IDLE:    if (req_any) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (rdy_hit || tmo_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Command capture on grant, ACCESS watchdog and completion capture
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= 1'b1;
      gnt_r    <= 1'b0;
      timer    <= '0;
      addr_r   <= '0;
      wdata_r  <= '0;
      strb_r   <= '0;
      we_r     <= 1'b0;
      rdata_r  <= '0;
      err_r    <= 1'b0;
    end else begin
      if (state != ACCESS) timer <= '0;
      case (state)
        IDLE: begin
          if (req_any) begin
            addr_r   <= winner ? bus.req1_addr  : bus.req0_addr;
            wdata_r  <= winner ? bus.req1_wdata : bus.req0_wdata;
            strb_r   <= winner ? bus.req1_strb  : bus.req0_strb;
            we_r     <= winner ? bus.req1_we    : bus.req0_we;
            gnt_r    <= winner;
            last_gnt <= winner;
          end
        end
        ACCESS: begin
          if (rdy_hit) begin
            rdata_r <= we_r ? '0 : bus.p_rdata;
            err_r   <= 1'b0;
            we_r    <= 1'b0;
            timer   <= '0;
          end else if (tmo_hit) begin
            rdata_r <= '0;
            err_r   <= 1'b1;
            we_r    <= 1'b0;
            timer   <= '0;
          end else begin
            // bounded by TMO_LAST, so this never wraps
            timer <= timer + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // done pulse and its payload reach only the granted requester
  assign done0 = (state == DONE) && !gnt_r;
  assign done1 = (state == DONE) &&  gnt_r;

  assign bus.req0_done  = done0;
  assign bus.req0_rdata = done0 ? rdata_r : '0;
  assign bus.req0_err   = done0 & err_r;
  assign bus.req1_done  = done1;
  assign bus.req1_rdata = done1 ? rdata_r : '0;
  assign bus.req1_err   = done1 & err_r;

  assign bus.p_sel   = (state == SETUP) || (state == ACCESS);
  assign bus.p_ce    = (state == ACCESS);
  assign bus.p_we    = we_r;
  assign bus.p_addr  = addr_r;
  assign bus.p_wdata = wdata_r;
  assign bus.p_strb  = strb_r;
  assign bus.gnt_id  = gnt_r;

endmodule
`default_nettype wire

// File: tb/tb_pgr_apb_cmd_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_pgr_apb_cmd_arb
// Brief    : Self-checking bench for pgr_apb_cmd_arb (TIMEOUT=8): vector table
//            of single transfers plus round-robin and mid-transfer reset runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pgr_apb_cmd_arb;

  localparam int          TMO = 8;
  localparam logic [15:0] A0  = 16'h0200;
  localparam logic [15:0] A1  = 16'h0300;

  typedef struct {
    bit          id;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    bit          we;
    int          waits;     // ACCESS cycles before p_rdy (0 = first cycle)
    bit          stray;     // drive p_rdy=1 outside ACCESS
    logic [31:0] srd;       // slave read data
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_acc;   // expected number of ACCESS cycles
  } vec_t;

  typedef struct {
    bit          id;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total  = 0;
  int   passed = 0;
  exp_t sb[$];
  vec_t vecs[7];

  pgr_apb_cmd_arb_if #(.AW(16), .DW(32), .SW(4)) bus ();

  pgr_apb_cmd_arb #(.AW(16), .DW(32), .SW(4), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_req(input bit id, input bit en, input logic [15:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb, input bit we);
    if (id) begin
      bus.req1_en = en; bus.req1_addr = addr; bus.req1_wdata = wdata;
      bus.req1_strb = strb; bus.req1_we = we;
    end else begin
      bus.req0_en = en; bus.req0_addr = addr; bus.req0_wdata = wdata;
      bus.req0_strb = strb; bus.req0_we = we;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req0_en = 1'b0;
    bus.req1_en = 1'b0;
    bus.p_rdy   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sel"},   bus.p_sel, 0);
    chk({tag, "_ce"},    bus.p_ce, 0);
    chk({tag, "_we"},    bus.p_we, 0);
    chk({tag, "_addr"},  bus.p_addr, 0);
    chk({tag, "_wdata"}, bus.p_wdata, 0);
    chk({tag, "_strb"},  bus.p_strb, 0);
    chk({tag, "_gnt"},   bus.gnt_id, 0);
    chk({tag, "_done"},  {bus.req1_done, bus.req0_done}, 0);
    chk({tag, "_rdata"}, {bus.req1_rdata, bus.req0_rdata}, 0);
    chk({tag, "_err"},   {bus.req1_err, bus.req0_err}, 0);
  endtask

  // One transfer from a single requester; caller is at a negedge with DUT idle.
  task automatic run_txn(input vec_t v);
    int   edges = 0;
    int   acc   = 0;
    bit   seen  = 0;
    bit   act_id;
    exp_t e;
    e.id = v.id; e.rdata = v.exp_rdata; e.err = v.exp_err;
    sb.push_back(e);
    set_req(v.id, 1'b1, v.addr, v.wdata, v.strb, v.we);
    bus.p_rdy   = v.stray;
    bus.p_rdata = v.srd;
    while (!seen && edges < 200) begin
      @(posedge clk); edges++;
      @(negedge clk);
      if (edges == 1) chk("setup_phase", {bus.p_sel, bus.p_ce}, 2'b10);
      if (bus.p_sel) begin
        chk("bus_addr",  bus.p_addr, v.addr);
        chk("bus_wdata", bus.p_wdata, v.wdata);
        chk("bus_strb",  bus.p_strb, v.strb);
        chk("bus_we",    bus.p_we, v.we);
        chk("bus_gnt",   bus.gnt_id, v.id);
      end
      if (bus.p_sel && bus.p_ce) acc++;
      chk("other_done", v.id ? bus.req0_done : bus.req1_done, 0);
      if (bus.req0_done || bus.req1_done) begin
        seen   = 1;
        act_id = bus.req1_done;
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          chk("done_id",    act_id, e.id);
          chk("done_rdata", act_id ? bus.req1_rdata : bus.req0_rdata, e.rdata);
          chk("done_err",   act_id ? bus.req1_err : bus.req0_err, e.err);
        end
        chk("acc_cycles", acc, v.exp_acc);
        chk("latency",    edges, 2 + v.exp_acc);
        chk("done_bus",   {bus.p_sel, bus.p_ce, bus.p_we}, 3'b000);
        chk("addr_hold",  bus.p_addr, v.addr);
        set_req(v.id, 1'b0, v.addr, v.wdata, v.strb, v.we);
        bus.p_rdy = 1'b0;
      end else begin
        bus.p_rdy = (bus.p_sel && bus.p_ce) ? ((acc - 1) == v.waits) : v.stray;
      end
    end
    if (!seen) chk("txn_no_done", 0, 1);
    bus.p_rdy = 1'b0;
    @(negedge clk);
    chk("back_idle", bus.p_sel, 0);
  endtask

  // Both requesters held for n reads; grants must alternate starting at req0.
  task automatic run_both(input int n);
    int   got = 0;
    int   cyc = 0;
    bit   act_id;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.id = bit'(i % 2); e.rdata = {16'hA5A5, (i % 2) ? A1 : A0}; e.err = 1'b0;
      sb.push_back(e);
    end
    set_req(1'b0, 1'b1, A0, 32'h0, 4'h0, 1'b0);
    set_req(1'b1, 1'b1, A1, 32'h0, 4'h0, 1'b0);
    while (got < n && cyc < 200) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (bus.p_sel && sb.size() > 0) begin
        chk("rr_gnt_id", bus.gnt_id, sb[0].id);
        chk("rr_addr",   bus.p_addr, sb[0].id ? A1 : A0);
      end
      chk("rr_single_done", bus.req0_done & bus.req1_done, 0);
      if (bus.req0_done || bus.req1_done) begin
        act_id = bus.req1_done;
        got++;
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          chk("rr_done_id", act_id, e.id);
          chk("rr_rdata",   act_id ? bus.req1_rdata : bus.req0_rdata, e.rdata);
          chk("rr_err",     act_id ? bus.req1_err : bus.req0_err, e.err);
        end
        if (got == n) begin
          bus.req0_en = 1'b0;
          bus.req1_en = 1'b0;
        end
      end
      bus.p_rdy   = bus.p_sel && bus.p_ce;
      bus.p_rdata = {16'hA5A5, bus.p_addr};
    end
    if (got < n) chk("rr_no_done", got, n);
    bus.p_rdy = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{1'b0, 16'h0010, 32'h0,        4'h0, 1'b0, 0,   1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1};
    vecs[1] = '{1'b1, 16'h0104, 32'h12345678, 4'hF, 1'b1, 5,   1'b0, 32'h55AA55AA, 32'h0,        1'b0, 6};
    vecs[2] = '{1'b0, 16'h0020, 32'h0,        4'h0, 1'b0, 100, 1'b0, 32'hCAFEF00D, 32'h0,        1'b1, TMO};
    vecs[3] = '{1'b0, 16'h0024, 32'h0,        4'h0, 1'b0, 7,   1'b0, 32'h0BADF00D, 32'h0BADF00D, 1'b0, TMO};
    vecs[4] = '{1'b1, 16'h0108, 32'h0,        4'h0, 1'b0, 2,   1'b1, 32'h13579BDF, 32'h13579BDF, 1'b0, 3};
    vecs[5] = '{1'b1, 16'h010C, 32'hA0A0A0A0, 4'h3, 1'b1, 100, 1'b0, 32'h77777777, 32'h0,        1'b1, TMO};
    vecs[6] = '{1'b0, 16'h0030, 32'hFEEDFACE, 4'hC, 1'b1, 1,   1'b1, 32'h24682468, 32'h0,        1'b0, 2};

    bus.req0_en = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0; bus.req0_strb = '0; bus.req0_we = 1'b0;
    bus.req1_en = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0; bus.req1_strb = '0; bus.req1_we = 1'b0;
    bus.p_rdy = 1'b0; bus.p_rdata = '0;

    do_reset();
    chk_all_zero("reset");

    // stray p_rdy while idle
    bus.p_rdy   = 1'b1;
    bus.p_rdata = 32'hFFFFFFFF;
    repeat (3) begin
      @(negedge clk);
      chk("idle_stray_sel",  bus.p_sel, 0);
      chk("idle_stray_done", {bus.req1_done, bus.req0_done}, 0);
    end
    bus.p_rdy = 1'b0;

    for (int i = 0; i < 7; i++) run_txn(vecs[i]);

    do_reset();
    run_both(4);

    // reset in the middle of an ACCESS phase
    set_req(1'b1, 1'b1, A1, 32'h0, 4'h0, 1'b0);
    bus.p_rdy = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("pre_rst_no_done", {bus.req1_done, bus.req0_done}, 0);
    end
    chk("pre_rst_access", {bus.p_sel, bus.p_ce, bus.gnt_id}, 3'b111);
    rst = 1'b1;
    bus.req0_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("midrst");
    rst = 1'b0;
    run_both(2);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
